// File: rtl/wishbone_openram_responder.sv
// Wishbone classic-cycle slave driving one single-port OpenRAM macro.
// Each request becomes exactly one registered macro access; reads wait out
// the macro read latency before returning ack together with the data.
module wishbone_openram_responder #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [31:0]           wbs_adr_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [3:0]            sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_din_o,
    input  logic [31:0]           sram_dout_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           din_q, din_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;

    // Address bits outside the word index are decoded upstream.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        unique case (state_q)
            StIdle: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    csb_d   = 1'b0;
                    web_d   = ~wbs_we_i;
                    wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                    addr_d  = wbs_adr_i[ADDR_WIDTH+1:2];
                    din_d   = wbs_dat_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // The macro captures on this edge regardless of an abort.
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!wbs_cyc_i) begin
                    state_d = StIdle;
                end else if (!web_q) begin
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d   = 2'(READ_LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!wbs_cyc_i) begin
                    state_d = StIdle;
                end else if (cnt_q == 2'd0) begin
                    dat_d   = sram_dout_i;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAck: begin
                // Bus inputs are ignored here; a held strobe restarts from idle.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'b0000;
            addr_q  <= '0;
            din_q   <= 32'd0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign sram_csb_o   = csb_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = wmask_q;
    assign sram_addr_o  = addr_q;
    assign sram_din_o   = din_q;

endmodule

// File: tb/tb_wishbone_openram_responder.sv
// Bench for wishbone_openram_responder: two instances (read latency 1 and 3),
// each with its own macro model, checked against a word-array reference.
module tb_wishbone_openram_responder;

    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          stb   [2];
    logic          cyc   [2];
    logic          we    [2];
    logic [3:0]    sel   [2];
    logic [31:0]   wdat  [2];
    logic [31:0]   adr   [2];
    logic          ack   [2];
    logic [31:0]   rdat  [2];
    logic          csb   [2];
    logic          web   [2];
    logic [3:0]    wmask [2];
    logic [AW-1:0] maddr [2];
    logic [31:0]   din   [2];
    logic [31:0]   dout  [2];

    wishbone_openram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut_l1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]),
        .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_dat_i(wdat[0]), .wbs_adr_i(adr[0]),
        .wbs_ack_o(ack[0]), .wbs_dat_o(rdat[0]), .sram_csb_o(csb[0]), .sram_web_o(web[0]),
        .sram_wmask_o(wmask[0]), .sram_addr_o(maddr[0]), .sram_din_o(din[0]),
        .sram_dout_i(dout[0])
    );

    wishbone_openram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut_l3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]),
        .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_dat_i(wdat[1]), .wbs_adr_i(adr[1]),
        .wbs_ack_o(ack[1]), .wbs_dat_o(rdat[1]), .sram_csb_o(csb[1]), .sram_web_o(web[1]),
        .sram_wmask_o(wmask[1]), .sram_addr_o(maddr[1]), .sram_din_o(din[1]),
        .sram_dout_i(dout[1])
    );

    // Macro models: capture on the rising edge while csb is low; read data
    // emerges after the instance's latency in edges.
    bit [31:0] mem  [2][256];
    bit [31:0] pipe [2][3];
    bit [31:0] mac_word;
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!csb[d] && !web[d]) begin
                mac_word = mem[d][maddr[d]];
                for (int b = 0; b < 4; b++)
                    if (wmask[d][b]) mac_word[8*b +: 8] = din[d][8*b +: 8];
                mem[d][maddr[d]] <= mac_word;
            end
            if (!csb[d] && web[d]) pipe[d][0] <= mem[d][maddr[d]];
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign dout[0] = pipe[0][0];
    assign dout[1] = pipe[1][2];

    // Reference state: memory contents and the last completed read value.
    bit [31:0] ref_mem [2][256];
    bit [31:0] last_rd [2];
    int total = 0;
    int bad   = 0;

    function automatic int rl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // One Wishbone transaction started in cycle 0; checks latency, the macro
    // access and the returned data against the reference.
    task automatic run_txn(input int d, input bit w, input logic [31:0] a,
                           input logic [31:0] data, input logic [3:0] s,
                           output int ack_cyc, output logic [31:0] rd);
        int cn, issues, acks, exp_ack;
        bit seen;
        logic o_web;
        logic [3:0] o_mask;
        logic [AW-1:0] o_addr;
        logic [31:0] o_din, exp_rd, word;
        int idx;
        ack_cyc = -1; rd = '0; cn = 0; issues = 0; acks = 0; seen = 0;
        o_web = 1'bx; o_mask = 'x; o_addr = 'x; o_din = 'x;
        idx = int'(a[AW+1:2]);
        we[d] = w; adr[d] = a; wdat[d] = data; sel[d] = s; cyc[d] = 1'b1; stb[d] = 1'b1;
        while (!seen && cn < 16) begin
            @(posedge clk); #1; cn++;
            if (!csb[d]) begin
                issues++; o_web = web[d]; o_mask = wmask[d]; o_addr = maddr[d]; o_din = din[d];
            end
            if (ack[d]) begin
                seen = 1; acks++; ack_cyc = cn; rd = rdat[d]; cyc[d] = 1'b0; stb[d] = 1'b0;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); #1;
        if (!csb[d]) issues++;
        if (ack[d]) acks++;
        exp_ack = w ? 2 : 2 + rl(d);
        total++;
        if (ack_cyc !== exp_ack) begin
            bad++; $display("FAIL txn_ack_cycle inst=%0d we=%0b got=%0d want=%0d", d, w, ack_cyc, exp_ack);
        end
        total++;
        if (acks !== 1) begin
            bad++; $display("FAIL txn_ack_count inst=%0d got=%0d want=1", d, acks);
        end
        total++;
        if (issues !== 1) begin
            bad++; $display("FAIL txn_csb_cycles inst=%0d got=%0d want=1", d, issues);
        end
        total++;
        if (o_web !== ~w || o_addr !== a[AW+1:2]) begin
            bad++; $display("FAIL txn_web_addr inst=%0d got=%b/%h want=%b/%h", d, o_web, o_addr, ~w, a[AW+1:2]);
        end
        total++;
        if (o_mask !== (w ? s : 4'h0) || o_din !== data) begin
            bad++; $display("FAIL txn_mask_din inst=%0d got=%h/%h want=%h/%h", d, o_mask, o_din, (w ? s : 4'h0), data);
        end
        if (w) begin
            exp_rd = last_rd[d];
            word = ref_mem[d][idx];
            for (int b = 0; b < 4; b++)
                if (s[b]) word[8*b +: 8] = data[8*b +: 8];
            ref_mem[d][idx] = word;
        end else begin
            exp_rd = ref_mem[d][idx];
            last_rd[d] = exp_rd;
        end
        total++;
        if (rd !== exp_rd) begin
            bad++; $display("FAIL txn_dat_o inst=%0d we=%0b got=%h want=%h", d, w, rd, exp_rd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (csb[d] !== 1'b1 || web[d] !== 1'b1 || ack[d] !== 1'b0 || rdat[d] !== 32'd0) begin
                bad++; $display("FAIL reset_ctl inst=%0d got csb=%b web=%b ack=%b dat=%h want 1 1 0 0", d, csb[d], web[d], ack[d], rdat[d]);
            end
            total++;
            if (wmask[d] !== 4'h0 || maddr[d] !== '0 || din[d] !== 32'd0) begin
                bad++; $display("FAIL reset_data inst=%0d got wmask=%h addr=%h din=%h want 0", d, wmask[d], maddr[d], din[d]);
            end
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write(input int d);
        int ac; logic [31:0] rd;
        run_txn(d, 1'b1, 32'h3000_0014, 32'hDEAD_BEEF, 4'hF, ac, rd);
    endtask

    task automatic test_read(input int d);
        int ac; logic [31:0] rd;
        run_txn(d, 1'b0, 32'h3000_0014, 32'h0, 4'hF, ac, rd);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL read_word5 inst=%0d got=%h want=deadbeef", d, rd);
        end
    endtask

    task automatic test_byte_write(input int d);
        int ac; logic [31:0] rd;
        run_txn(d, 1'b1, 32'h3000_0014, 32'h00AA_0000, 4'h4, ac, rd);
        run_txn(d, 1'b0, 32'h3000_0014, 32'h0, 4'hF, ac, rd);
        total++;
        if (rd !== 32'hDEAA_BEEF) begin
            bad++; $display("FAIL byte_write inst=%0d got=%h want=deaabeef", d, rd);
        end
        // Zero byte mask still makes an access and acks, leaving memory intact.
        run_txn(d, 1'b1, 32'h3000_0014, 32'h1234_5678, 4'h0, ac, rd);
        run_txn(d, 1'b0, 32'h3000_0014, 32'h0, 4'hF, ac, rd);
        total++;
        if (rd !== 32'hDEAA_BEEF) begin
            bad++; $display("FAIL sel_zero_write inst=%0d got=%h want=deaabeef", d, rd);
        end
    endtask

    // Reset asserted between edges while a read is issuing on the slow instance.
    task automatic test_reset_mid();
        int acks;
        we[1] = 1'b0; adr[1] = 32'h3000_0014; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        total++;
        if (csb[1] !== 1'b0) begin
            bad++; $display("FAIL reset_mid_issue got csb=%b want 0", csb[1]);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (csb[1] !== 1'b1 || web[1] !== 1'b1 || ack[1] !== 1'b0 || rdat[1] !== 32'd0 || rdat[0] !== 32'd0) begin
            bad++; $display("FAIL reset_mid_async got csb=%b web=%b ack=%b dat=%h/%h want 1 1 0 0/0", csb[1], web[1], ack[1], rdat[1], rdat[0]);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ack[0] || ack[1]) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++; $display("FAIL reset_mid_lost got acks=%0d want=0", acks);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int ac, n_ack, n_iss, width_err;
        int ack_at [4];
        logic [31:0] got [4];
        logic [31:0] rd;
        bit prev;
        for (int i = 0; i < 4; i++) run_txn(d, 1'b1, 32'h3000_0080 + 32'(4 * i), $urandom, 4'hF, ac, rd);
        for (int i = 0; i < 4; i++) begin ack_at[i] = -100; got[i] = 'x; end
        n_ack = 0; n_iss = 0; width_err = 0; prev = 0;
        we[d] = 1'b0; sel[d] = 4'hF; adr[d] = 32'h3000_0080 | 32'($urandom_range(0, 3));
        cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (!csb[d]) n_iss++;
            if (ack[d]) begin
                if (prev) width_err++;
                if (n_ack < 4) begin ack_at[n_ack] = c; got[n_ack] = rdat[d]; end
                n_ack++;
                if (n_ack >= 4) begin cyc[d] = 1'b0; stb[d] = 1'b0; end
                else adr[d] = adr[d] + 32'd4;
            end
            prev = ack[d];
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        last_rd[d] = ref_mem[d][8'h23];
        total++;
        if (n_ack !== 4 || n_iss !== 4) begin
            bad++; $display("FAIL b2b_counts inst=%0d got acks=%0d accesses=%0d want 4/4", d, n_ack, n_iss);
        end
        total++;
        if (width_err !== 0) begin
            bad++; $display("FAIL b2b_ack_width inst=%0d got long_pulses=%0d want=0", d, width_err);
        end
        total++;
        if (ack_at[0] !== 2 + rl(d)) begin
            bad++; $display("FAIL b2b_first_ack inst=%0d got=%0d want=%0d", d, ack_at[0], 2 + rl(d));
        end
        for (int i = 1; i < 4; i++) begin
            total++;
            if (ack_at[i] - ack_at[i-1] !== 3 + rl(d)) begin
                bad++; $display("FAIL b2b_period inst=%0d n=%0d got=%0d want=%0d", d, i, ack_at[i] - ack_at[i-1], 3 + rl(d));
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== ref_mem[d][8'h20 + i]) begin
                bad++; $display("FAIL b2b_data inst=%0d n=%0d got=%h want=%h", d, i, got[i], ref_mem[d][8'h20 + i]);
            end
        end
    endtask

    // Drop cyc while waiting on read data; stb left high must not restart.
    task automatic test_abort(input int d);
        int ac, n_ack, n_iss, chg;
        logic [31:0] rd;
        n_ack = 0; n_iss = 0; chg = 0;
        we[d] = 1'b0; sel[d] = 4'hF; adr[d] = 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2);
        cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (!csb[d]) n_iss++;
            if (ack[d]) n_ack++;
            if (rdat[d] !== last_rd[d]) chg++;
            if (c == 2) cyc[d] = 1'b0;
        end
        stb[d] = 1'b0;
        total++;
        if (n_ack !== 0 || n_iss !== 1) begin
            bad++; $display("FAIL abort_no_ack inst=%0d got acks=%0d accesses=%0d want 0/1", d, n_ack, n_iss);
        end
        total++;
        if (chg !== 0) begin
            bad++; $display("FAIL abort_dat_hold inst=%0d got changed_cycles=%0d want=0", d, chg);
        end
        run_txn(d, 1'b1, 32'h3000_0000 | (32'($urandom_range(0, 15)) << 2), $urandom, 4'hF, ac, rd);
        total++;
        if (ac !== 2) begin
            bad++; $display("FAIL abort_next_write inst=%0d got ack_cycle=%0d want=2", d, ac);
        end
    endtask

    task automatic test_random(input int d);
        int ac; logic [31:0] rd, a;
        for (int n = 0; n < 30; n++) begin
            a = $urandom;
            a[9:2] = 8'($urandom_range(0, 15));
            run_txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), ac, rd);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0;
            wdat[d] = 32'd0; adr[d] = 32'd0; last_rd[d] = 32'd0;
        end
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_write(d);
            test_read(d);
            test_byte_write(d);
        end
        test_reset_mid();
        for (int d = 0; d < 2; d++) begin
            test_back_to_back(d);
            test_abort(d);
            test_random(d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
